// File: rtl/reg_rename_file_if.sv
// Issue/commit/broadcast/lookup bundle between the rename stage and reg_rename_file.
interface reg_rename_file_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned BC_NUM = 2
);
    logic                     rdy_in;
    logic                     roll_back;

    logic                     issue_valid;
    logic [REG_AW-1:0]        issue_rd;
    logic                     issue_rd_en;
    logic [TAG_W-1:0]         issue_tag;

    logic                     rs1_en;
    logic                     rs2_en;
    logic [REG_AW-1:0]        rs1;
    logic [REG_AW-1:0]        rs2;

    logic                     commit_valid;
    logic [REG_AW-1:0]        commit_rd;
    logic [TAG_W-1:0]         commit_tag;
    logic [XLEN-1:0]          commit_value;

    logic [BC_NUM-1:0]        bc_valid;
    logic [BC_NUM*TAG_W-1:0]  bc_tag;
    logic [BC_NUM*XLEN-1:0]   bc_value;

    logic                     q1_busy;
    logic                     q2_busy;
    logic [TAG_W-1:0]         q1_tag;
    logic [TAG_W-1:0]         q2_tag;
    logic [XLEN-1:0]          v1;
    logic [XLEN-1:0]          v2;
    logic [REG_AW:0]          busy_count;

    modport master (
        output rdy_in, roll_back,
        output issue_valid, issue_rd, issue_rd_en, issue_tag,
        output rs1_en, rs2_en, rs1, rs2,
        output commit_valid, commit_rd, commit_tag, commit_value,
        output bc_valid, bc_tag, bc_value,
        input  q1_busy, q2_busy, q1_tag, q2_tag, v1, v2, busy_count
    );

    modport slave (
        input  rdy_in, roll_back,
        input  issue_valid, issue_rd, issue_rd_en, issue_tag,
        input  rs1_en, rs2_en, rs1, rs2,
        input  commit_valid, commit_rd, commit_tag, commit_value,
        input  bc_valid, bc_tag, bc_value,
        output q1_busy, q2_busy, q1_tag, q2_tag, v1, v2, busy_count
    );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with rename status and a speculative result cache.
// Lookups are combinational and bypass same-cycle commit and broadcasts.
module reg_rename_file #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned BC_NUM  = 2
) (
    input logic               clk,
    input logic               rst_in,
    reg_rename_file_if.slave  bus
);
    localparam int unsigned CNT_W = REG_AW + 1;
    localparam int unsigned NPORT = 2;

    logic [XLEN-1:0]    value_q      [REG_NUM];
    logic [XLEN-1:0]    value_d      [REG_NUM];
    logic [TAG_W-1:0]   tag_q        [REG_NUM];
    logic [TAG_W-1:0]   tag_d        [REG_NUM];
    logic [XLEN-1:0]    spec_value_q [REG_NUM];
    logic [XLEN-1:0]    spec_value_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [REG_NUM-1:0] spec_ready_q;
    logic [REG_NUM-1:0] spec_ready_d;
    logic [CNT_W-1:0]   busy_count_q;
    logic [CNT_W-1:0]   busy_count_d;

    logic               rs_en  [NPORT];
    logic [REG_AW-1:0]  rs_idx [NPORT];
    logic               lk_busy [NPORT];
    logic [TAG_W-1:0]   lk_tag  [NPORT];
    logic [XLEN-1:0]    lk_val  [NPORT];

    // Next state: rollback > issue > matching commit > first matching broadcast.
    // Register 0 is never touched so it stays at its reset value of zero.
    always_comb begin : next_state_comb
        logic bc_hit;
        value_d      = value_q;
        tag_d        = tag_q;
        spec_value_d = spec_value_q;
        busy_d       = busy_q;
        spec_ready_d = spec_ready_q;
        busy_count_d = '0;
        bc_hit       = 1'b0;
        if (bus.rdy_in) begin
            for (int unsigned r = 1; r < REG_NUM; r++) begin
                bc_hit = 1'b0;
                if (bus.commit_valid && bus.commit_rd == REG_AW'(r)) begin
                    value_d[r] = bus.commit_value;
                end
                if (bus.roll_back) begin
                    busy_d[r]       = 1'b0;
                    tag_d[r]        = '0;
                    spec_ready_d[r] = 1'b0;
                end else if (bus.issue_valid && bus.issue_rd_en
                             && bus.issue_rd == REG_AW'(r)) begin
                    busy_d[r]       = 1'b1;
                    tag_d[r]        = bus.issue_tag;
                    spec_ready_d[r] = 1'b0;
                end else if (bus.commit_valid && bus.commit_rd == REG_AW'(r)
                             && busy_q[r] && tag_q[r] == bus.commit_tag) begin
                    busy_d[r]       = 1'b0;
                    tag_d[r]        = '0;
                    spec_ready_d[r] = 1'b0;
                end else if (busy_q[r] && !spec_ready_q[r]) begin
                    for (int unsigned k = 0; k < BC_NUM; k++) begin
                        if (!bc_hit && bus.bc_valid[k]
                            && bus.bc_tag[k*TAG_W +: TAG_W] == tag_q[r]) begin
                            spec_ready_d[r] = 1'b1;
                            spec_value_d[r] = bus.bc_value[k*XLEN +: XLEN];
                            bc_hit          = 1'b1;
                        end
                    end
                end
            end
        end
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            busy_count_d = busy_count_d + CNT_W'(busy_d[r]);
        end
    end

    // State registers with synchronous reset; rdy_in low holds via next-state logic.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                value_q[r]      <= '0;
                tag_q[r]        <= '0;
                spec_value_q[r] <= '0;
            end
            busy_q       <= '0;
            spec_ready_q <= '0;
            busy_count_q <= '0;
        end else begin
            value_q      <= value_d;
            tag_q        <= tag_d;
            spec_value_q <= spec_value_d;
            busy_q       <= busy_d;
            spec_ready_q <= spec_ready_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign rs_en[0]  = bus.rs1_en;
    assign rs_en[1]  = bus.rs2_en;
    assign rs_idx[0] = bus.rs1;
    assign rs_idx[1] = bus.rs2;

    // Operand lookup against pre-issue state, bypassing commit then broadcasts.
    always_comb begin : lookup_comb
        logic bc_hit;
        bc_hit = 1'b0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            lk_busy[p] = 1'b0;
            lk_tag[p]  = '0;
            lk_val[p]  = '0;
            bc_hit     = 1'b0;
            if (rs_en[p] && rs_idx[p] != '0) begin
                if (!busy_q[rs_idx[p]]) begin
                    lk_val[p] = value_q[rs_idx[p]];
                end else if (spec_ready_q[rs_idx[p]]) begin
                    lk_val[p] = spec_value_q[rs_idx[p]];
                end else if (bus.commit_valid && bus.commit_rd == rs_idx[p]
                             && bus.commit_tag == tag_q[rs_idx[p]]) begin
                    lk_val[p] = bus.commit_value;
                end else begin
                    for (int unsigned k = 0; k < BC_NUM; k++) begin
                        if (!bc_hit && bus.bc_valid[k]
                            && bus.bc_tag[k*TAG_W +: TAG_W] == tag_q[rs_idx[p]]) begin
                            lk_val[p] = bus.bc_value[k*XLEN +: XLEN];
                            bc_hit    = 1'b1;
                        end
                    end
                    if (!bc_hit) begin
                        lk_busy[p] = 1'b1;
                        lk_tag[p]  = tag_q[rs_idx[p]];
                    end
                end
            end
        end
    end

    assign bus.q1_busy    = lk_busy[0];
    assign bus.q1_tag     = lk_tag[0];
    assign bus.v1         = lk_val[0];
    assign bus.q2_busy    = lk_busy[1];
    assign bus.q2_tag     = lk_tag[1];
    assign bus.v2         = lk_val[1];
    assign bus.busy_count = busy_count_q;
endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: directed scenarios plus randomized
// traffic against an array-based reference model of the rename rules.
module tb_reg_rename_file;
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned BC_NUM  = 2;

    logic clk;
    logic rst_in;
    int   n_checks;
    int   n_fail;

    // Reference model state
    logic [XLEN-1:0]  m_val  [REG_NUM];
    logic             m_busy [REG_NUM];
    logic [TAG_W-1:0] m_tag  [REG_NUM];
    logic             m_sr   [REG_NUM];
    logic [XLEN-1:0]  m_sv   [REG_NUM];

    reg_rename_file_if #(.REG_AW(REG_AW), .XLEN(XLEN), .TAG_W(TAG_W), .BC_NUM(BC_NUM)) bus ();

    reg_rename_file #(
        .REG_NUM(REG_NUM), .REG_AW(REG_AW), .XLEN(XLEN), .TAG_W(TAG_W), .BC_NUM(BC_NUM)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_count();
        int c = 0;
        for (int r = 0; r < REG_NUM; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    // Expected lookup result straight from the priority rules.
    task automatic model_lookup(input logic en, input logic [REG_AW-1:0] rs,
                                output logic eb, output logic [TAG_W-1:0] et,
                                output logic [XLEN-1:0] ev);
        int r;
        eb = 1'b0; et = '0; ev = '0;
        r = int'(rs);
        if (!en || r == 0) return;
        if (!m_busy[r]) begin ev = m_val[r]; return; end
        if (m_sr[r]) begin ev = m_sv[r]; return; end
        if (bus.commit_valid && int'(bus.commit_rd) == r && bus.commit_tag == m_tag[r]) begin
            ev = bus.commit_value; return;
        end
        for (int k = 0; k < BC_NUM; k++) begin
            if (bus.bc_valid[k] && bus.bc_tag[k*TAG_W +: TAG_W] == m_tag[r]) begin
                ev = bus.bc_value[k*XLEN +: XLEN]; return;
            end
        end
        eb = 1'b1; et = m_tag[r];
    endtask

    // Model update for one clock edge, computed from the inputs held at that edge.
    task automatic model_step();
        logic cm, iss, done;
        if (rst_in) begin
            for (int r = 0; r < REG_NUM; r++) begin
                m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0; m_sr[r] = 1'b0; m_sv[r] = '0;
            end
            return;
        end
        if (!bus.rdy_in) return;
        for (int r = 1; r < REG_NUM; r++) begin
            cm  = bus.commit_valid && int'(bus.commit_rd) == r;
            iss = bus.issue_valid && bus.issue_rd_en && int'(bus.issue_rd) == r;
            if (bus.roll_back) begin
                m_busy[r] = 1'b0; m_tag[r] = '0; m_sr[r] = 1'b0;
            end else if (iss) begin
                m_busy[r] = 1'b1; m_tag[r] = bus.issue_tag; m_sr[r] = 1'b0;
            end else if (cm && m_busy[r] && m_tag[r] == bus.commit_tag) begin
                m_busy[r] = 1'b0; m_tag[r] = '0; m_sr[r] = 1'b0;
            end else if (m_busy[r] && !m_sr[r]) begin
                done = 1'b0;
                for (int k = 0; k < BC_NUM; k++) begin
                    if (!done && bus.bc_valid[k] && bus.bc_tag[k*TAG_W +: TAG_W] == m_tag[r]) begin
                        m_sr[r] = 1'b1; m_sv[r] = bus.bc_value[k*XLEN +: XLEN]; done = 1'b1;
                    end
                end
            end
            if (cm) m_val[r] = bus.commit_value;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.rdy_in = 1'b1; bus.roll_back = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_rd_en = 1'b0; bus.issue_tag = '0;
        bus.rs1_en = 1'b0; bus.rs2_en = 1'b0; bus.rs1 = '0; bus.rs2 = '0;
        bus.commit_valid = 1'b0; bus.commit_rd = '0; bus.commit_tag = '0; bus.commit_value = '0;
        bus.bc_valid = '0; bus.bc_tag = '0; bus.bc_value = '0;
    endtask

    task automatic issue(input int rd, input int tag);
        bus.issue_valid = 1'b1; bus.issue_rd_en = 1'b1;
        bus.issue_rd = REG_AW'(rd); bus.issue_tag = TAG_W'(tag);
    endtask

    task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] val);
        bus.commit_valid = 1'b1; bus.commit_rd = REG_AW'(rd);
        bus.commit_tag = TAG_W'(tag); bus.commit_value = val;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        bus.rs1_en = 1'b1; bus.rs1 = 5'd5;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.q1_busy); end
        n_checks++; if (bus.q1_tag !== 4'd0) begin n_fail++; $display("FAIL reset_tag got %0d want 0", bus.q1_tag); end
        n_checks++; if (bus.v1 !== 32'd0) begin n_fail++; $display("FAIL reset_v1 got %h want 0", bus.v1); end
        n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.busy_count); end
    endtask

    task automatic test_spec_bypass();
        idle();
        issue(3, 7);
        tick();
        idle();
        bus.rs1_en = 1'b1; bus.rs1 = 5'd3;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b1 || bus.q1_tag !== 4'd7) begin
            n_fail++; $display("FAIL issued_busy got busy=%b tag=%0d want busy=1 tag=7", bus.q1_busy, bus.q1_tag); end
        bus.bc_valid = 2'b10;
        bus.bc_tag[TAG_W +: TAG_W] = 4'd7;
        bus.bc_value[XLEN +: XLEN] = 32'hDEAD;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b0 || bus.v1 !== 32'hDEAD) begin
            n_fail++; $display("FAIL bc_bypass got busy=%b v=%h want busy=0 v=0000dead", bus.q1_busy, bus.v1); end
        tick();
        bus.bc_valid = '0; bus.bc_tag = '0; bus.bc_value = '0;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b0 || bus.v1 !== 32'hDEAD) begin
            n_fail++; $display("FAIL spec_hit got busy=%b v=%h want busy=0 v=0000dead", bus.q1_busy, bus.v1); end
        n_checks++; if (bus.busy_count !== 6'd1) begin n_fail++; $display("FAIL spec_count got %0d want 1", bus.busy_count); end
    endtask

    task automatic test_commit_tags();
        idle(); issue(3, 2); tick();
        idle(); issue(3, 9); tick();
        idle(); commit(3, 2, 32'h11); tick();
        idle();
        bus.rs1_en = 1'b1; bus.rs1 = 5'd3;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b1 || bus.q1_tag !== 4'd9) begin
            n_fail++; $display("FAIL stale_commit got busy=%b tag=%0d want busy=1 tag=9", bus.q1_busy, bus.q1_tag); end
        commit(3, 9, 32'h22);
        tick();
        idle();
        bus.rs1_en = 1'b1; bus.rs1 = 5'd3;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b0 || bus.v1 !== 32'h22) begin
            n_fail++; $display("FAIL final_commit got busy=%b v=%h want busy=0 v=00000022", bus.q1_busy, bus.v1); end
        n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL commit_count got %0d want 0", bus.busy_count); end
    endtask

    task automatic test_same_cycle_issue();
        idle(); commit(4, 0, 32'h44); tick();
        idle(); issue(4, 5);
        bus.rs1_en = 1'b1; bus.rs1 = 5'd4; bus.rs2_en = 1'b1; bus.rs2 = 5'd4;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b0 || bus.v1 !== 32'h44 || bus.q2_busy !== 1'b0 || bus.v2 !== 32'h44) begin
            n_fail++; $display("FAIL same_cycle got b1=%b v1=%h b2=%b v2=%h want 0/44/0/44",
                               bus.q1_busy, bus.v1, bus.q2_busy, bus.v2); end
        tick();
        bus.issue_valid = 1'b0;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b1 || bus.q1_tag !== 4'd5 || bus.q2_busy !== 1'b1 || bus.q2_tag !== 4'd5) begin
            n_fail++; $display("FAIL after_issue got b1=%b t1=%0d b2=%b t2=%0d want 1/5/1/5",
                               bus.q1_busy, bus.q1_tag, bus.q2_busy, bus.q2_tag); end
    endtask

    task automatic test_rollback();
        idle(); issue(6, 1); tick();
        idle(); issue(7, 3); tick();
        idle();
        bus.bc_valid = 2'b01; bus.bc_tag[0 +: TAG_W] = 4'd3; bus.bc_value[0 +: XLEN] = 32'h77;
        tick();
        idle();
        bus.rs2_en = 1'b1; bus.rs2 = 5'd7;
        #1;
        n_checks++; if (bus.busy_count !== 6'd3) begin n_fail++; $display("FAIL pre_rb_count got %0d want 3", bus.busy_count); end
        n_checks++; if (bus.q2_busy !== 1'b0 || bus.v2 !== 32'h77) begin
            n_fail++; $display("FAIL pre_rb_spec got busy=%b v=%h want 0/00000077", bus.q2_busy, bus.v2); end
        bus.roll_back = 1'b1;
        commit(6, 1, 32'h55);
        issue(8, 2);
        tick();
        idle();
        bus.rs1_en = 1'b1; bus.rs1 = 5'd6; bus.rs2_en = 1'b1; bus.rs2 = 5'd7;
        #1;
        n_checks++; if (bus.busy_count !== 6'd0) begin n_fail++; $display("FAIL rb_count got %0d want 0", bus.busy_count); end
        n_checks++; if (bus.q1_busy !== 1'b0 || bus.v1 !== 32'h55) begin
            n_fail++; $display("FAIL rb_commit got busy=%b v=%h want 0/00000055", bus.q1_busy, bus.v1); end
        n_checks++; if (bus.q2_busy !== 1'b0 || bus.v2 !== 32'h0) begin
            n_fail++; $display("FAIL rb_spec_gone got busy=%b v=%h want 0/00000000", bus.q2_busy, bus.v2); end
        bus.rs1 = 5'd8;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b0 || bus.q1_tag !== 4'd0) begin
            n_fail++; $display("FAIL rb_issue_ignored got busy=%b tag=%0d want 0/0", bus.q1_busy, bus.q1_tag); end
    endtask

    task automatic test_reg0_and_hold();
        idle(); issue(0, 1); commit(0, 1, 32'hFF); tick();
        idle();
        bus.rs1_en = 1'b1; bus.rs1 = 5'd0;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b0 || bus.v1 !== 32'h0 || bus.busy_count !== 6'd0) begin
            n_fail++; $display("FAIL reg0 got busy=%b v=%h cnt=%0d want 0/0/0", bus.q1_busy, bus.v1, bus.busy_count); end
        bus.rdy_in = 1'b0;
        issue(9, 4); commit(10, 0, 32'hAB);
        tick();
        idle();
        bus.rs1_en = 1'b1; bus.rs1 = 5'd9; bus.rs2_en = 1'b1; bus.rs2 = 5'd10;
        #1;
        n_checks++; if (bus.q1_busy !== 1'b0 || bus.busy_count !== 6'd0) begin
            n_fail++; $display("FAIL hold_issue got busy=%b cnt=%0d want 0/0", bus.q1_busy, bus.busy_count); end
        n_checks++; if (bus.v2 !== 32'h0) begin n_fail++; $display("FAIL hold_commit got %h want 00000000", bus.v2); end
    endtask

    task automatic test_random();
        logic eb; logic [TAG_W-1:0] et; logic [XLEN-1:0] ev;
        int cr;
        idle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.rdy_in      = ($urandom_range(0, 9) != 0);
            bus.roll_back   = ($urandom_range(0, 29) == 0);
            bus.issue_valid = ($urandom_range(0, 2) != 0);
            bus.issue_rd_en = ($urandom_range(0, 5) != 0);
            bus.issue_rd    = REG_AW'($urandom_range(0, 7));
            bus.issue_tag   = TAG_W'($urandom);
            bus.rs1_en      = ($urandom_range(0, 7) != 0);
            bus.rs2_en      = ($urandom_range(0, 7) != 0);
            bus.rs1         = REG_AW'($urandom_range(0, 7));
            bus.rs2         = REG_AW'($urandom_range(0, 7));
            cr = $urandom_range(0, 7);
            bus.commit_valid = ($urandom_range(0, 1) != 0);
            bus.commit_rd    = REG_AW'(cr);
            bus.commit_tag   = ($urandom_range(0, 9) < 7) ? m_tag[cr] : TAG_W'($urandom);
            bus.commit_value = $urandom;
            for (int k = 0; k < BC_NUM; k++) begin
                bus.bc_valid[k] = ($urandom_range(0, 2) == 0);
                bus.bc_tag[k*TAG_W +: TAG_W] = ($urandom_range(0, 1) != 0)
                    ? m_tag[$urandom_range(0, 7)] : TAG_W'($urandom);
                bus.bc_value[k*XLEN +: XLEN] = $urandom;
            end
            #1;
            model_lookup(bus.rs1_en, bus.rs1, eb, et, ev);
            n_checks++; if (bus.q1_busy !== eb || bus.q1_tag !== et || bus.v1 !== ev) begin
                n_fail++; $display("FAIL rand_port1 cyc=%0d got b=%b t=%0d v=%h want b=%b t=%0d v=%h",
                                   cyc, bus.q1_busy, bus.q1_tag, bus.v1, eb, et, ev); end
            model_lookup(bus.rs2_en, bus.rs2, eb, et, ev);
            n_checks++; if (bus.q2_busy !== eb || bus.q2_tag !== et || bus.v2 !== ev) begin
                n_fail++; $display("FAIL rand_port2 cyc=%0d got b=%b t=%0d v=%h want b=%b t=%0d v=%h",
                                   cyc, bus.q2_busy, bus.q2_tag, bus.v2, eb, et, ev); end
            n_checks++; if (int'(bus.busy_count) != model_count()) begin
                n_fail++; $display("FAIL rand_count cyc=%0d got %0d want %0d", cyc, bus.busy_count, model_count()); end
            tick();
        end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_in   = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_spec_bypass();
        test_commit_tags();
        test_same_cycle_issue();
        test_rollback();
        test_reg0_and_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Parametrised successor to the architectural register / rename-status file in the out-of-order core.
- Holds, per architectural register:
  - the committed value;
  - a busy flag and the ROB tag of the newest in-flight producer;
  - a speculative result cache, filled from any of BC_NUM broadcast channels.
- Serves two operand lookups per cycle to issue/RS, with same-cycle bypass from broadcasts and commit.
- Rollback discards all speculative state.
- The committed value is written only at ROB commit.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is hard-wired zero.
- REG_AW, 5, register index width (2^REG_AW >= REG_NUM).
- XLEN, 32, data width.
- TAG_W, 4, ROB tag width.
- BC_NUM, 2, number of result broadcast channels (ALU-RS, LSB, ...).

Ports:
- clk  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low = hold all state
- roll_back  in  1  mispredict flush
- issue_valid  in  1  instruction renaming this cycle
- issue_rd  in  REG_AW  destination register
- issue_rd_en  in  1  instruction writes rd
- issue_tag  in  TAG_W  ROB entry allocated
- rs1_en / rs2_en  in  1 each  operand lookup enable
- rs1 / rs2  in  REG_AW each  source registers
- commit_valid  in  1  ROB head commits
- commit_rd  in  REG_AW  destination
- commit_tag  in  TAG_W  ROB entry committing
- commit_value  in  XLEN  result
- bc_valid  in  BC_NUM  per-channel broadcast valid
- bc_tag  in  BC_NUM*TAG_W  packed tags; channel k at [k*TAG_W +: TAG_W]
- bc_value  in  BC_NUM*XLEN  packed values
- q1_busy / q2_busy  out  1 each  operand not yet available
- q1_tag / q2_tag  out  TAG_W each  producer tag when busy, else 0
- v1 / v2  out  XLEN each  operand value when not busy, else 0
- busy_count  out  REG_AW+1  registered count of busy registers

Behaviour:
- Reset (rst_in=1 at posedge): all value, tag, busy, spec_ready, spec_value cleared; busy_count=0. Outputs are combinational, so post-reset lookups give busy=0, tag=0, value=0.
- rdy_in=0: no state changes. Lookups still answer combinationally.
- Lookup priority (combinational, per port, evaluated in this order):
  1. Enable low, or rs==0: busy=0, value=0.
  2. Register not busy: committed value.
  3. Busy and spec_ready: spec_value, busy=0.
  4. Busy, commit_valid with commit_rd==rs and commit_tag==tag: commit_value, busy=0.
  5. Busy, any bc_valid[k] with bc_tag[k]==tag: bc_value[k], busy=0; lowest k wins if several match.
  6. Otherwise: busy=1, tag output, value 0.
- Lookups reflect state before this cycle's issue. rs==issue_rd in the same cycle returns the previous producer, never issue_tag.
- Issue (issue_valid & issue_rd_en & issue_rd!=0 & !roll_back):
  - tag[rd] <= issue_tag; busy[rd] <= 1; spec_ready[rd] <= 0.
- Commit (commit_valid & commit_rd!=0):
  - value[rd] <= commit_value, always, including in a roll_back cycle.
  - Busy/tag/spec_ready cleared only if busy & tag[rd]==commit_tag & no same-cycle issue to rd.
- Broadcast: for each register with busy & !spec_ready & tag==bc_tag[k] & bc_valid[k]:
  - spec_ready <= 1; spec_value <= bc_value[k] (lowest k wins).
  - Suppressed if a same-cycle issue targets that register (issue wins).
  - Broadcast never writes the committed value and never clears busy.
- roll_back=1: busy, tag and spec_ready cleared for all registers; issue ignored; commit value write still applied; broadcasts ignored.
- busy_count: registered population count of busy after this cycle's updates; 0 after reset or rollback.
- Register 0: never busy, never written; lookup always returns 0.

Test Plan:
- Reset, then lookup rs1=5 -> q1_busy=0, v1=0, busy_count=0.
- Issue rd=3 tag=7; next cycle lookup rs1=3 -> q1_busy=1, q1_tag=7. Same cycle bc ch1 tag=7 value=0xDEAD -> v1=0xDEAD, busy=0. Following cycle -> spec hit 0xDEAD, busy_count still 1.
- Issue rd=3 tag=2, then issue rd=3 tag=9; commit rd=3 tag=2 value=0x11 -> value[3]=0x11, register stays busy with tag 9. Commit tag 9 value=0x22 -> busy clear, lookup returns 0x22.
- Same cycle: issue rd=4 tag=5 and lookup rs1=4, rs2=4 -> outputs show prior state (not busy, old value); next cycle busy tag 5.
- Three registers busy, spec ready on one; roll_back with commit rd=6 value=0x55 -> all busy clear, busy_count=0, lookup rs1=6 -> 0x55, spec values discarded.
- Issue rd=0 tag=1, commit rd=0 value=0xFF -> rs1=0 gives 0 not busy; rdy_in=0 while issue asserted -> no state change.
